// File: rtl/alarm_controller.sv
// Alarm clock controller: BCD alarm-time storage/editing plus IDLE/RINGING/SNOOZE sequencing.
// Define ALARM_AUTO_OFF_EN to add a ring timeout of AUTO_OFF_SEC ticks.
//
// state     | meaning
// ST_IDLE   | not sounding; waits for a rising match while armed
// ST_RING   | sounding; buzzer beeps at 1 Hz
// ST_SNOOZE | silent; counting down SNOOZE_SEC ticks before ringing again
module alarm_controller #(
    parameter int SNOOZE_SEC   = 300,
    parameter int AUTO_OFF_SEC = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [3:0] t_h_tens,
    input  logic [3:0] t_h_ones,
    input  logic [3:0] t_m_tens,
    input  logic [3:0] t_m_ones,
    input  logic       alarm_en,
    input  logic       set_alarm,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       snooze_btn,
    input  logic       dismiss_btn,
    output logic [3:0] a_h_tens,
    output logic [3:0] a_h_ones,
    output logic [3:0] a_m_tens,
    output logic [3:0] a_m_ones,
    output logic       ringing,
    output logic       snoozing,
    output logic       buzzer
);
    localparam int SNZ_W = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [3:0]       btn_prev;
    logic             match;
    logic             match_prev;
    logic             trigger;
    logic             e_hour;
    logic             e_min;
    logic             e_snooze;
    logic             e_dismiss;
    logic             abort;
    logic             ring_done;
    logic [SNZ_W-1:0] snz_cnt;
    logic [SNZ_W-1:0] snz_cnt_next;
    logic             beep_phase;
    logic             beep_next;
    logic             ringing_next;
    logic             snoozing_next;
    logic             buzzer_next;

    assign e_hour    = inc_hour    & ~btn_prev[0];
    assign e_min     = inc_min     & ~btn_prev[1];
    assign e_snooze  = snooze_btn  & ~btn_prev[2];
    assign e_dismiss = dismiss_btn & ~btn_prev[3];

    assign match   = ({t_h_tens, t_h_ones, t_m_tens, t_m_ones} ==
                      {a_h_tens, a_h_ones, a_m_tens, a_m_ones});
    assign trigger = match & ~match_prev;
    assign abort   = e_dismiss | ~alarm_en | set_alarm;

`ifdef ALARM_AUTO_OFF_EN
    localparam int RING_W = (AUTO_OFF_SEC > 0) ? $clog2(AUTO_OFF_SEC + 1) : 1;
    logic [RING_W-1:0] ring_cnt;

    assign ring_done = (state == ST_RING) && tick_1hz &&
                       (ring_cnt == RING_W'(AUTO_OFF_SEC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            ring_cnt <= '0;
        end else if (next_state == ST_RING && state != ST_RING) begin
            ring_cnt <= '0;
        end else if (state == ST_RING && tick_1hz) begin
            ring_cnt <= ring_cnt + 1'b1;
        end
    end
`else
    assign ring_done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            match_prev <= 1'b0;
            btn_prev   <= '0;
            snz_cnt    <= '0;
            beep_phase <= 1'b0;
            ringing    <= 1'b0;
            snoozing   <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            state      <= next_state;
            match_prev <= match;
            btn_prev   <= {dismiss_btn, snooze_btn, inc_min, inc_hour};
            snz_cnt    <= snz_cnt_next;
            beep_phase <= beep_next;
            ringing    <= ringing_next;
            snoozing   <= snoozing_next;
            buzzer     <= buzzer_next;
        end
    end

    // Dismiss/disarm/edit beat snooze, snooze beats the auto-off timeout.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (trigger && alarm_en && !set_alarm) next_state = ST_RING;
            end
            ST_RING: begin
                if (abort)          next_state = ST_IDLE;
                else if (e_snooze)  next_state = ST_SNOOZE;
                else if (ring_done) next_state = ST_IDLE;
            end
            ST_SNOOZE: begin
                if (abort)                                  next_state = ST_IDLE;
                else if (tick_1hz && snz_cnt <= SNZ_W'(1))  next_state = ST_RING;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        snz_cnt_next = snz_cnt;
        beep_next    = beep_phase;
        if (next_state == ST_SNOOZE && state != ST_SNOOZE) begin
            snz_cnt_next = SNZ_W'(SNOOZE_SEC);
        end else if (state == ST_SNOOZE && tick_1hz && snz_cnt != '0) begin
            snz_cnt_next = snz_cnt - 1'b1;
        end
        if (next_state == ST_RING && state != ST_RING) begin
            beep_next = 1'b1;
        end else if (state == ST_RING && tick_1hz) begin
            beep_next = ~beep_phase;
        end
        ringing_next  = (next_state == ST_RING);
        snoozing_next = (next_state == ST_SNOOZE);
        buzzer_next   = ringing_next & beep_next;
    end

    // Hour wraps 23 -> 00, minute wraps 59 -> 00 without carrying into the hour.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_h_tens <= '0;
            a_h_ones <= '0;
            a_m_tens <= '0;
            a_m_ones <= '0;
        end else if (set_alarm) begin
            if (e_hour) begin
                if (a_h_tens == 4'd2 && a_h_ones == 4'd3) begin
                    a_h_tens <= '0;
                    a_h_ones <= '0;
                end else if (a_h_ones == 4'd9) begin
                    a_h_tens <= a_h_tens + 4'd1;
                    a_h_ones <= '0;
                end else begin
                    a_h_ones <= a_h_ones + 4'd1;
                end
            end
            if (e_min) begin
                if (a_m_ones == 4'd9) begin
                    a_m_ones <= '0;
                    a_m_tens <= (a_m_tens == 4'd5) ? 4'd0 : a_m_tens + 4'd1;
                end else begin
                    a_m_ones <= a_m_ones + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus random stimulus
// against a behavioural model of the alarm rules.
module tb_alarm_controller;
    localparam int SNOOZE_SEC   = 300;
    localparam int AUTO_OFF_SEC = 60;
`ifdef ALARM_AUTO_OFF_EN
    localparam bit AUTO_OFF = 1'b1;
`else
    localparam bit AUTO_OFF = 1'b0;
`endif
    localparam int M_IDLE   = 0;
    localparam int M_RING   = 1;
    localparam int M_SNOOZE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic [3:0] t_h_tens = '0;
    logic [3:0] t_h_ones = '0;
    logic [3:0] t_m_tens = '0;
    logic [3:0] t_m_ones = '0;
    logic       alarm_en = 1'b0;
    logic       set_alarm = 1'b0;
    logic       inc_hour = 1'b0;
    logic       inc_min = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       dismiss_btn = 1'b0;
    logic [3:0] a_h_tens;
    logic [3:0] a_h_ones;
    logic [3:0] a_m_tens;
    logic [3:0] a_m_ones;
    logic       ringing;
    logic       snoozing;
    logic       buzzer;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    int       m_ah = 0;
    int       m_am = 0;
    int       m_mode = M_IDLE;
    int       m_left = 0;
    int       m_beep = 0;
    int       m_rt = 0;
    bit       m_mprev = 1'b0;
    bit [3:0] m_prev = '0;

    alarm_controller #(.SNOOZE_SEC(SNOOZE_SEC), .AUTO_OFF_SEC(AUTO_OFF_SEC)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .t_h_tens(t_h_tens), .t_h_ones(t_h_ones), .t_m_tens(t_m_tens), .t_m_ones(t_m_ones),
        .alarm_en(alarm_en), .set_alarm(set_alarm),
        .inc_hour(inc_hour), .inc_min(inc_min), .snooze_btn(snooze_btn), .dismiss_btn(dismiss_btn),
        .a_h_tens(a_h_tens), .a_h_ones(a_h_ones), .a_m_tens(a_m_tens), .a_m_ones(a_m_ones),
        .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    function automatic int bcd_hhmm(input int h, input int m);
        return ((h / 10) << 12) | ((h % 10) << 8) | ((m / 10) << 4) | (m % 10);
    endfunction

    function automatic int alarm_hhmm();
        return int'({a_h_tens, a_h_ones, a_m_tens, a_m_ones});
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: time/alarm as integer hours and minutes, mode as a small integer.
    always @(posedge clk) begin
        int  ah, am, md, left, beep, rt;
        bit  match, trig, e_h, e_m, e_s, e_d, leave;
        ah = m_ah; am = m_am; md = m_mode; left = m_left; beep = m_beep; rt = m_rt;
        started <= 1'b1;
        if (reset) begin
            ah = 0; am = 0; md = M_IDLE; left = 0; beep = 0; rt = 0;
            m_mprev <= 1'b0;
            m_prev  <= '0;
        end else begin
            match = (int'(t_h_tens) * 10 + int'(t_h_ones) == m_ah) &&
                    (int'(t_m_tens) * 10 + int'(t_m_ones) == m_am);
            trig  = match && !m_mprev;
            e_h   = inc_hour    && !m_prev[0];
            e_m   = inc_min     && !m_prev[1];
            e_s   = snooze_btn  && !m_prev[2];
            e_d   = dismiss_btn && !m_prev[3];
            if (set_alarm && e_h) ah = (ah + 1) % 24;
            if (set_alarm && e_m) am = (am + 1) % 60;
            leave = e_d || !alarm_en || set_alarm;
            if (md == M_IDLE) begin
                if (trig && alarm_en && !set_alarm) begin
                    md = M_RING; beep = 1; rt = 0;
                end
            end else if (md == M_RING) begin
                if (leave) md = M_IDLE;
                else if (e_s) begin
                    md = M_SNOOZE; left = SNOOZE_SEC;
                end else if (tick_1hz) begin
                    rt = rt + 1;
                    beep = 1 - beep;
                    if (AUTO_OFF && rt == AUTO_OFF_SEC) md = M_IDLE;
                end
            end else begin
                if (leave) md = M_IDLE;
                else if (tick_1hz) begin
                    left = left - 1;
                    if (left == 0) begin
                        md = M_RING; beep = 1; rt = 0;
                    end
                end
            end
            m_mprev <= match;
            m_prev  <= {dismiss_btn, snooze_btn, inc_min, inc_hour};
        end
        m_ah <= ah; m_am <= am; m_mode <= md; m_left <= left; m_beep <= beep; m_rt <= rt;
    end

    always @(negedge clk) begin
        if (started) begin
            check("cmp_ringing",  int'(ringing),  int'(m_mode == M_RING));
            check("cmp_snoozing", int'(snoozing), int'(m_mode == M_SNOOZE));
            check("cmp_buzzer",   int'(buzzer),   int'(m_mode == M_RING && m_beep == 1));
            check("cmp_alarm",    alarm_hhmm(),   bcd_hhmm(m_ah, m_am));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m);
        t_h_tens = 4'(h / 10);
        t_h_ones = 4'(h % 10);
        t_m_tens = 4'(m / 10);
        t_m_ones = 4'(m % 10);
    endtask

    // which: 0 inc_hour, 1 inc_min, 2 snooze, 3 dismiss, 4 snooze+dismiss together
    task automatic press(input int which);
        case (which)
            0: inc_hour = 1'b1;
            1: inc_min = 1'b1;
            2: snooze_btn = 1'b1;
            3: dismiss_btn = 1'b1;
            default: begin
                snooze_btn = 1'b1;
                dismiss_btn = 1'b1;
            end
        endcase
        cyc();
        inc_hour = 1'b0; inc_min = 1'b0; snooze_btn = 1'b0; dismiss_btn = 1'b0;
        cyc();
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        cyc();
        tick_1hz = 1'b0;
        cyc();
    endtask

    task automatic ring_now();
        set_time(7, 31);
        cyc(); cyc();
        set_time(7, 30);
        cyc(); cyc();
    endtask

    initial begin
        int n;
        set_time(12, 0);
        reset = 1'b1;
        repeat (3) cyc();
        check("reset_ringing", int'(ringing), 0);
        check("reset_buzzer", int'(buzzer), 0);
        check("reset_alarm", alarm_hhmm(), 0);
        reset = 1'b0;
        set_alarm = 1'b1;
        cyc();
        repeat (7) press(0);
        repeat (30) press(1);
        check("edit_0730", alarm_hhmm(), 16'h0730);
        repeat (17) press(0);
        check("edit_hour_wrap", alarm_hhmm(), 16'h0030);
        repeat (30) press(1);
        check("edit_min_wrap", alarm_hhmm(), 16'h0000);
        repeat (7) press(0);
        repeat (30) press(1);

        set_alarm = 1'b0;
        alarm_en = 1'b1;
        set_time(7, 29);
        repeat (3) cyc();
        check("pre_ring", int'(ringing), 0);
        set_time(7, 30);
        cyc();
        check("ring_start", int'(ringing), 1);
        check("buzz_start", int'(buzzer), 1);
        tick_1hz = 1'b1; cyc();
        check("buzz_toggle1", int'(buzzer), 0);
        tick_1hz = 1'b0; cyc();
        tick_1hz = 1'b1; cyc();
        check("buzz_toggle2", int'(buzzer), 1);
        tick_1hz = 1'b0; cyc();

        press(2);
        check("snooze_on", int'(snoozing), 1);
        check("snooze_buzz", int'(buzzer), 0);
        n = 0;
        while (!ringing && n < 400) begin
            tick();
            n++;
        end
        check("snooze_ticks", n, 300);
        press(3);
        repeat (20) tick();
        check("no_rering", int'(ringing), 0);

        ring_now();
        check("ring_again", int'(ringing), 1);
        press(4);
        check("both_ring", int'(ringing), 0);
        check("both_snooze", int'(snoozing), 0);

        ring_now();
        press(2);
        alarm_en = 1'b0;
        cyc();
        check("disarm_snooze", int'(snoozing), 0);
        alarm_en = 1'b1;
        repeat (320) tick();
        check("disarm_no_ring", int'(ringing), 0);

        ring_now();
        repeat (59) tick();
        check("ring_59", int'(ringing), 1);
`ifdef ALARM_AUTO_OFF_EN
        tick();
        check("autooff_60", int'(ringing), 0);
`else
        repeat (61) tick();
        check("ring_120", int'(ringing), 1);
        press(3);
`endif

        ring_now();
        press(2);
        check("pre_reset_snooze", int'(snoozing), 1);
        reset = 1'b1;
        cyc();
        check("rst_snoozing", int'(snoozing), 0);
        check("rst_ringing", int'(ringing), 0);
        check("rst_buzzer", int'(buzzer), 0);
        check("rst_alarm", alarm_hhmm(), 0);
        reset = 1'b0;
        repeat (310) tick();
        check("rst_no_ring", int'(ringing), 0);

        reset = 1'b1;
        set_time(0, 0);
        cyc();
        reset = 1'b0;
        cyc();
        check("post_reset_ring", int'(ringing), 1);
        press(3);

        for (int i = 0; i < 4000; i++) begin
            int sel;
            tick_1hz    = ($urandom_range(0, 3) == 0);
            inc_hour    = ($urandom_range(0, 5) == 0);
            inc_min     = ($urandom_range(0, 5) == 0);
            snooze_btn  = ($urandom_range(0, 11) == 0);
            dismiss_btn = ($urandom_range(0, 29) == 0);
            if (set_alarm) set_alarm = ($urandom_range(0, 7) != 0);
            else           set_alarm = ($urandom_range(0, 79) == 0);
            if (alarm_en)  alarm_en = ($urandom_range(0, 199) != 0);
            else           alarm_en = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) begin
                sel = $urandom_range(0, 3);
                if (sel <= 1)      set_time(m_ah, m_am);
                else if (sel == 2) set_time(m_ah, (m_am + 1) % 60);
                else               set_time($urandom_range(0, 23), $urandom_range(0, 59));
            end
            cyc();
        end
        reset = 1'b0;
        tick_1hz = 1'b0; inc_hour = 1'b0; inc_min = 1'b0; snooze_btn = 1'b0; dismiss_btn = 1'b0;
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
